// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter slice: default widths, the
// transaction timeout and the arbiter FSM state encoding.
package sdram_pkg;

   localparam int SDRAM_ADDR_W  = 24;
   localparam int SDRAM_DATA_W  = 16;
   localparam int SDRAM_TIMEOUT = 255;

   // Width of the timeout counter; wide enough for the largest legal TIMEOUT.
   localparam int SDRAM_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the two requester ports and the controller command port.
// The arbiter takes the slave view; requesters and controller sit on the
// master view.
interface sdram_arbiter_if #(
   parameter int ADDR_W = sdram_pkg::SDRAM_ADDR_W,
   parameter int DATA_W = sdram_pkg::SDRAM_DATA_W
) ();

   // Requester 0 (CPU data path)
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_ack;
   logic              p0_err;
   logic [DATA_W-1:0] p0_rdata;

   // Requester 1 (display / DMA fetcher)
   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_ack;
   logic              p1_err;
   logic [DATA_W-1:0] p1_rdata;

   // Controller command port
   logic              mem_start;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p0_ack, p0_err, p0_rdata,
      output p1_ack, p1_err, p1_rdata,
      output mem_start, mem_we, mem_addr, mem_wdata,
      input  mem_done, mem_rdata
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p0_ack, p0_err, p0_rdata,
      input  p1_ack, p1_err, p1_rdata,
      input  mem_start, mem_we, mem_addr, mem_wdata,
      output mem_done, mem_rdata
   );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner select for the two-port SDRAM arbiter.
// Default: round-robin on a tie, the port that did not win last time wins.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority: port 0 always wins a tie
// and last_gnt is ignored (port 1 can starve).
module sdram_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   output logic gnt,
   output logic any
);

   // Pick the winning port index from the current requests.
   always_comb begin
      // NOTE: defaults first so every path assigns gnt/any and no latch is inferred.
      gnt = 1'b0;
      any = req0 | req1;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      if (!req0 && req1) begin
         gnt = 1'b1;
      end
`else
      if (req0 && req1) begin
         gnt = ~last_gnt;
      end else if (req1) begin
         gnt = 1'b1;
      end
`endif
   end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   // History is irrelevant under fixed priority.
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of sdram_controller. Grants one 16-bit read or
// write at a time, strobes mem_start, waits for mem_done (bounded by
// TIMEOUT cycles) and returns ack/err/rdata to the winning port.
// Policy: round-robin by default; SDRAM_ARB_FIXED_PRIO_EN selects fixed
// priority (resolved inside sdram_arb_pick).
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int ADDR_W  = SDRAM_ADDR_W,
   parameter int DATA_W  = SDRAM_DATA_W,
   parameter int TIMEOUT = SDRAM_TIMEOUT  // legal range 1..65535
) (
   input  logic           clk,
   input  logic           reset,
   sdram_arbiter_if.slave bus
);

   localparam logic [SDRAM_CNT_W-1:0] TIMEOUT_CNT = SDRAM_CNT_W'(TIMEOUT);

   arb_state_t              state;
   logic                    gnt;        // port owning the current transaction
   logic                    last_gnt;   // port served by the previous transaction
   logic [SDRAM_CNT_W-1:0]  cnt;        // cycles spent in WAIT

   logic                    pick_gnt;
   logic                    pick_any;

   // Registered outputs
   logic [1:0]              ack_q;
   logic [1:0]              err_q;
   logic [DATA_W-1:0]       rdata0_q;
   logic [DATA_W-1:0]       rdata1_q;
   logic                    mem_start_q;
   logic                    mem_we_q;
   logic [ADDR_W-1:0]       mem_addr_q;
   logic [DATA_W-1:0]       mem_wdata_q;

   sdram_arb_pick u_pick (
      .req0     (bus.p0_req),
      .req1     (bus.p1_req),
      .last_gnt (last_gnt),
      .gnt      (pick_gnt),
      .any      (pick_any)
   );

   // Arbiter FSM with all port and controller outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         gnt         <= 1'b0;
         last_gnt    <= 1'b1;   // port 0 wins the first tie
         cnt         <= '0;
         ack_q       <= '0;
         err_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_start_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees pre-edge state.
         // Strobes are single-cycle unless re-asserted below.
         mem_start_q <= 1'b0;
         ack_q       <= '0;
         err_q       <= '0;

         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt         <= pick_gnt;
                  mem_we_q    <= pick_gnt ? bus.p1_we    : bus.p0_we;
                  mem_addr_q  <= pick_gnt ? bus.p1_addr  : bus.p0_addr;
                  mem_wdata_q <= pick_gnt ? bus.p1_wdata : bus.p0_wdata;
                  mem_start_q <= 1'b1;   // high during the ISSUE cycle
                  state       <= ISSUE;
               end
            end

            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end

            WAIT: begin
               if (bus.mem_done) begin
                  // Writes leave the requester's read data untouched.
                  if (!mem_we_q) begin
                     if (gnt) begin
                        rdata1_q <= bus.mem_rdata;
                     end else begin
                        rdata0_q <= bus.mem_rdata;
                     end
                  end
                  ack_q[gnt] <= 1'b1;
                  state      <= DONE;
               end else if (cnt == TIMEOUT_CNT) begin
                  // Controller stalled: abort with error, read data kept.
                  ack_q[gnt] <= 1'b1;
                  err_q[gnt] <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + SDRAM_CNT_W'(1);
               end
            end

            DONE: begin
               // ack is visible this cycle; no new grant until IDLE.
               last_gnt <= gnt;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.p0_ack    = ack_q[0];
   assign bus.p1_ack    = ack_q[1];
   assign bus.p0_err    = err_q[0];
   assign bus.p1_err    = err_q[1];
   assign bus.p0_rdata  = rdata0_q;
   assign bus.p1_rdata  = rdata1_q;
   assign bus.mem_start = mem_start_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a small controller model.
// Expected acks are queued as stimulus is driven and retired in order when
// the DUT acknowledges. Build with SDRAM_ARB_FIXED_PRIO_EN to check the
// fixed-priority variant.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

   sdram_arbiter #(
      .ADDR_W  (24),
      .DATA_W  (16),
      .TIMEOUT (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected acknowledge, in completion order.
   typedef struct {
      bit          port;
      bit          we;
      logic [23:0] addr;
      logic [15:0] wdata;
      bit          err;
      logic [15:0] rdata;
      int          lat;     // cycles from mem_start to ack
   } exp_t;

   exp_t sb[$];
   exp_t e;

   // Controller model: done model_lat cycles after mem_start (0 = never).
   logic [15:0] mem_model [logic [23:0]];
   int          model_lat = 2;
   int          model_cnt = 0;
   bit          spur_done = 1'b0;
   logic [23:0] model_addr = '0;

   always @(negedge clk) begin
      bus.mem_done  = spur_done;
      bus.mem_rdata = '0;
      if (reset) begin
         model_cnt = 0;
      end else begin
         if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
               bus.mem_done  = 1'b1;
               bus.mem_rdata = mem_model.exists(model_addr) ? mem_model[model_addr] : 16'h0000;
            end
         end
         if (bus.mem_start && model_lat > 0) begin
            model_cnt  = model_lat;
            model_addr = bus.mem_addr;
            if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
         end
      end
   end

   // Monitor: command stability while in flight, ack retirement.
   bit          inflight  = 1'b0;
   int          start_cyc = 0;
   logic [15:0] shadow0   = '0;
   logic [15:0] shadow1   = '0;

   always @(negedge clk) begin
      if (reset) begin
         inflight = 1'b0;
         shadow0  = '0;
         shadow1  = '0;
      end else begin
         if (bus.mem_start) begin
            inflight  = 1'b1;
            start_cyc = cyc;
         end
         if (inflight && sb.size() > 0) begin
            check("mem_we",    32'(bus.mem_we),    32'(sb[0].we));
            check("mem_addr",  32'(bus.mem_addr),  32'(sb[0].addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
         end
         if (bus.p0_ack || bus.p1_ack) begin
            if (sb.size() == 0) begin
               check("unexp_ack", 32'({bus.p0_ack, bus.p1_ack}), 32'd0);
            end else begin
               e = sb.pop_front();
               check("ack_port", 32'({bus.p0_ack, bus.p1_ack}), e.port ? 32'd1 : 32'd2);
               check("err", 32'(e.port ? bus.p1_err : bus.p0_err), 32'(e.err));
               if (!e.we && !e.err) begin
                  if (e.port) shadow1 = e.rdata;
                  else        shadow0 = e.rdata;
               end
               check("p0_rdata", 32'(bus.p0_rdata), 32'(shadow0));
               check("p1_rdata", 32'(bus.p1_rdata), 32'(shadow1));
               check("ack_lat", 32'(cyc - start_cyc), 32'(e.lat));
            end
            inflight = 1'b0;
         end
      end
   end

   // Hold requests until the given number of acks per port, then drop.
   task automatic serve(input int n0_in, input int n1_in);
      int n0 = n0_in;
      int n1 = n1_in;
      int budget = 400;
      bit a0;
      bit a1;
      while ((n0 > 0 || n1 > 0) && budget > 0) begin
         @(negedge clk);
         a0 = bus.p0_ack;
         a1 = bus.p1_ack;
         @(posedge clk);
         #1;
         if (a0 && n0 > 0) begin
            n0--;
            if (n0 == 0) bus.p0_req = 1'b0;
            else         bus.p0_addr = bus.p0_addr + 24'd1;
         end
         if (a1 && n1 > 0) begin
            n1--;
            if (n1 == 0) bus.p1_req = 1'b0;
            else         bus.p1_addr = bus.p1_addr + 24'd1;
         end
         budget--;
      end
      if (budget == 0) check("serve_budget", 32'(n0 + n1), 32'd0);
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
   endtask

   task automatic single(input bit port, input bit we, input logic [23:0] addr,
                         input logic [15:0] wdata, input int lat, input bit err,
                         input logic [15:0] rd);
      int t0;
      model_lat = lat;
      sb.push_back('{port, we, addr, wdata, err, rd, err ? TMO + 2 : lat + 1});
      @(posedge clk);
      #1;
      if (port) begin
         bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
      end else begin
         bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
      end
      t0 = cyc;
      serve(port ? 0 : 1, port ? 1 : 0);
      check("start_lat", 32'(start_cyc - t0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;

      mem_model[24'h000001] = 16'hABCD;
      for (int i = 0; i < 4; i++) mem_model[24'h000100 + 24'(i)] = 16'h1000 + 16'(i);
      for (int i = 0; i < 2; i++) mem_model[24'h000200 + 24'(i)] = 16'h2000 + 16'(i);
      mem_model[24'h000041] = 16'h4141;
      mem_model[24'h000300] = 16'h3030;

      #2 reset = 1'b1;
      @(negedge clk);
      check("rst_p0_ack",    32'(bus.p0_ack),    32'd0);
      check("rst_p1_ack",    32'(bus.p1_ack),    32'd0);
      check("rst_p0_err",    32'(bus.p0_err),    32'd0);
      check("rst_p1_err",    32'(bus.p1_err),    32'd0);
      check("rst_p0_rdata",  32'(bus.p0_rdata),  32'd0);
      check("rst_p1_rdata",  32'(bus.p1_rdata),  32'd0);
      check("rst_mem_start", 32'(bus.mem_start), 32'd0);
      check("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;

      // Contention: both ports held for four transactions.
      model_lat = 2;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      sb.push_back('{1'b0, 1'b0, 24'h000100, 16'h0, 1'b0, 16'h1000, 3});
      sb.push_back('{1'b0, 1'b0, 24'h000101, 16'h0, 1'b0, 16'h1001, 3});
      sb.push_back('{1'b0, 1'b0, 24'h000102, 16'h0, 1'b0, 16'h1002, 3});
      sb.push_back('{1'b0, 1'b0, 24'h000103, 16'h0, 1'b0, 16'h1003, 3});
`else
      sb.push_back('{1'b0, 1'b0, 24'h000100, 16'h0, 1'b0, 16'h1000, 3});
      sb.push_back('{1'b1, 1'b0, 24'h000200, 16'h0, 1'b0, 16'h2000, 3});
      sb.push_back('{1'b0, 1'b0, 24'h000101, 16'h0, 1'b0, 16'h1001, 3});
      sb.push_back('{1'b1, 1'b0, 24'h000201, 16'h0, 1'b0, 16'h2001, 3});
`endif
      @(posedge clk);
      #1;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 24'h000100; bus.p0_wdata = '0;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 24'h000200; bus.p1_wdata = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      serve(4, 0);
`else
      serve(2, 2);
`endif

      // Single read, single write, read-back.
      single(1'b0, 1'b0, 24'h000001, 16'h0000, 3, 1'b0, 16'hABCD);
      single(1'b1, 1'b1, 24'h00FFFF, 16'h1234, 3, 1'b0, 16'h0000);
      single(1'b0, 1'b0, 24'h00FFFF, 16'h0000, 1, 1'b0, 16'h1234);

      // Timeout, then a normal transaction.
      single(1'b0, 1'b0, 24'h000040, 16'h0000, 0, 1'b1, 16'h0000);
      single(1'b0, 1'b0, 24'h000041, 16'h0000, 4, 1'b0, 16'h4141);

      // Spurious done in IDLE.
      @(posedge clk); #1 spur_done = 1'b1;
      @(posedge clk); #1 spur_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("spur_start", 32'(bus.mem_start), 32'd0);
         check("spur_state", 32'(dut.state), 32'(IDLE));
      end

      // Reset in the middle of WAIT.
      model_lat = 0;
      @(posedge clk);
      #1;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 24'h000055; bus.p0_wdata = 16'h0055;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_start) break;
      end
      check("mid_started", 32'(bus.mem_start), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("mid_in_wait", 32'(dut.state), 32'(WAIT));
      #1 reset = 1'b1;
      #1;
      check("mid_state",     32'(dut.state),     32'(IDLE));
      check("mid_mem_start", 32'(bus.mem_start), 32'd0);
      check("mid_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("mid_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("mid_p0_ack",    32'(bus.p0_ack),    32'd0);
      check("mid_p0_rdata",  32'(bus.p0_rdata),  32'd0);
      check("mid_p1_rdata",  32'(bus.p1_rdata),  32'd0);
      bus.p0_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;

      single(1'b1, 1'b0, 24'h000300, 16'h0000, 2, 1'b0, 16'h3030);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single-transaction port of `sdram_controller` between two requesters: port 0 is the CPU data path and port 1 is the display/DMA fetcher. It accepts one 16-bit read or write per grant and issues it to the controller with a start pulse. It waits for the controller's completion, returns read data and an acknowledge to the winning requester, and aborts with an error if the controller stalls.

## Interface
- `ADDR_W`, 24: word address width, matches controller `addr`.
- `DATA_W`, 16: data width, matches controller `data_in`/`data_out`.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_done`; must be 1..65535.

Ports:
- `clk` in 1: single clock, same clock as `sdram_controller`.
- `reset` in 1: asynchronous, active-high.
- `p0_req`, `p1_req` in 1: request; held high with command stable until ack.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in `ADDR_W`: word address.
- `p0_wdata`, `p1_wdata` in `DATA_W`: write data.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `p0_err`, `p1_err` out 1: valid with ack; 1 = timed out.
- `p0_rdata`, `p1_rdata` out `DATA_W`: read data; valid with ack, held until the next ack on that port.
- `mem_start` out 1: one-cycle command strobe to the controller.
- `mem_we` out 1: latched write enable.
- `mem_addr` out `ADDR_W`: latched address.
- `mem_wdata` out `DATA_W`: latched write data.
- `mem_done` in 1: controller completion, one-cycle pulse.
- `mem_rdata` in `DATA_W`: controller read data, valid while `mem_done` is high.

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **IDLE:** if any `req` is high, choose a winner by policy and latch `we`/`addr`/`wdata` into the `mem_*` registers and `gnt` (the winner index) → ISSUE. If no `req` is high, stay in IDLE.
- **ISSUE:** `mem_start`=1 for exactly this cycle; clear the timeout counter → WAIT.
- **WAIT:** the counter increments each cycle.
  - On `mem_done`=1: capture `mem_rdata` into the granted port's `rdata` (reads only; writes leave `rdata` unchanged) → DONE, err=0.
  - If the counter reaches `TIMEOUT` with no `mem_done`: → DONE, err=1, `rdata` unchanged.
- **DONE:** the granted port's `ack`=1 and its `err` carries the flag. Update `last_gnt` ← `gnt` → IDLE.
- **Default policy, round-robin:** if both requests are high, the port ≠ `last_gnt` wins. If only one is high, it wins.
- **Handshake:**
  - A requester samples `ack` at a clock edge. In the following cycle its `req` either is low or presents a new command.
  - The arbiter never re-grants during DONE.
  - Dropping `req` before ack is illegal; the latched command completes anyway.
- `mem_done` outside WAIT is ignored.
- `mem_we`/`mem_addr`/`mem_wdata` stay stable from ISSUE through DONE.

## Timing
- **Reset values:** all `ack`/`err`/`rdata`/`mem_*` outputs = 0; `last_gnt`=1, so port 0 wins the first tie.
- **Latency:** `req` sampled at edge E0 → `mem_start` high in cycle E0+1. If `mem_done` is high in cycle E0+1+N (N≥1), `ack` is high in cycle E0+2+N.
- **Throughput:** minimum of 4 cycles per transaction, plus the controller's latency.
- **Timeout:** `ack` with err=1 arrives `TIMEOUT`+3 cycles after the grant edge.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and drops `mem_start`. The in-flight transaction is lost and no ack is issued. The controller shares the same `reset`.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN` defined: port 0 always wins when both requests are high, and `last_gnt` is unused. Port 1 can starve.
- Macro undefined: round-robin as above.

## Structure
- Shared package `sdram_pkg` holds:
  - the `ADDR_W`/`DATA_W` defaults;
  - the FSM state typedef `arb_state_t`, encoded IDLE=0, ISSUE=1, WAIT=2, DONE=3;
  - the `TIMEOUT` default.
- One sub-module, `sdram_arb_pick`: combinational winner select from (`req0`, `req1`, `last_gnt`) → `gnt`, `any`. The policy macro is resolved there.

## Test plan
- **Single read:** `p0_req` read at addr 0x000001, model returns 0xABCD after 3 cycles → `mem_start` 1 cycle after sampling, `p0_ack`=1, `p0_err`=0, `p0_rdata`=0xABCD; `p1_ack` stays 0.
- **Single write:** `p1_req` write 0x1234 to 0x00FFFF → `mem_we`=1, `mem_addr`=0x00FFFF, `mem_wdata`=0x1234 from ISSUE to DONE; `p1_ack` pulses; `p1_rdata` unchanged.
- **Contention, round-robin:** both requests held continuously for 4 transactions → grant order 0,1,0,1. With `SDRAM_ARB_FIXED_PRIO_EN` defined → 0,0,0,0.
- **Timeout:** `TIMEOUT`=8 and the model never asserts `mem_done` → `p0_ack` and `p0_err`=1 exactly 11 cycles after the grant edge; the next request is served normally.
- **Spurious done:** `mem_done` pulsed in IDLE → no state change and no ack.
- **Reset mid-WAIT:** assert `reset` during WAIT → outputs zero, FSM in IDLE, no ack. After reset, `p1_req` alone is granted.
